ru_write_arbiter: RTL and testbench
===================================

// Module: ru_write_arbiter
// PURPOSE
//  Owns the single write port of the 32x32 register unit. Sequences a post-reset clear of x1..x31,
//  then shares the port between core writeback (priority) and a debug/loader channel with a
//  valid/ready handshake and a one-entry holding buffer. Stalls the core when the debug entry starves.
//  Sits between the writeback mux / debug bridge and RUrd/RUDatawr/RUWr.
// PARAMETERS
//  NREG           32  number of architectural registers (index width = $clog2(NREG))
//  DW             32  data width
//  STARVE_LIMIT    8  cycles a buffered debug write may wait before the core is stalled (>=1)
//  CLEAR_ON_RESET  1  1: run CLEAR sequence after reset; 0: go straight to RUN
// PORTS
//  CLK          in   1   clock, all state on rising edge
//  RSTn         in   1   asynchronous active-low reset
//  core_wr      in   1   core writeback enable (RUWr from control)
//  core_rd      in   5   core destination register
//  core_data    in   DW  core writeback data
//  dbg_valid    in   1   debug write request
//  dbg_ready    out  1   debug request accepted when valid&&ready at rising edge
//  dbg_rd       in   5   debug destination register
//  dbg_data     in   DW  debug write data
//  dbg_done     out  1   one-cycle pulse: buffered debug write retired
//  ru_wr        out  1   to register unit write enable
//  ru_rd        out  5   to register unit destination
//  ru_data      out  DW  to register unit write data
//  core_stall   out  1   core must hold PC and repeat instruction this cycle
//  busy         out  1   CLEAR in progress
//  drop_err     out  1   sticky: core_wr seen while core_stall was high
// BEHAVIOUR
//  Reset (RSTn=0, async): state=CLEAR (RUN if CLEAR_ON_RESET=0), clr_idx=1, buf empty, wait_cnt=0,
//   dbg_done=0, drop_err=0. Outputs follow state: busy=1, core_stall=1, dbg_ready=0, ru_wr=1 in CLEAR.
//  ru_* outputs are combinational from state/buffer/core inputs; the write lands at the next CLK edge.
//  Rule: ru_wr is never 1 with ru_rd==0. Idle: ru_wr=0, ru_rd=0, ru_data=0.
//  CLEAR: each cycle ru_wr=1, ru_rd=clr_idx, ru_data=0; clr_idx++. After the edge writing
//   idx NREG-1 (31 cycles total), state->RUN. busy=core_stall=1, dbg_ready=0 throughout.
//  RUN, per cycle, in priority order:
//   1. starve = buf_full && wait_cnt>=STARVE_LIMIT -> core_stall=1, buffer drains (ru_*=buffer).
//   2. core_wr && core_rd!=0 -> ru_*=core; buffer (if full) holds, wait_cnt++ (saturating).
//   3. else buffer full -> ru_*=buffer, drains at edge.
//  Drain: buf_full clears at the edge, wait_cnt->0, dbg_done=1 next cycle. Buffered rd==0: drains
//   with ru_wr=0 (discarded) but still counts as retired (dbg_done pulses).
//  dbg_ready = (state==RUN) && !buf_full. No same-cycle refill: an entry draining this cycle keeps
//   dbg_ready=0; new request accepted next cycle earliest. Accepted entry drains no earlier than the
//   cycle after acceptance (buffer registered, no bypass).
//  core_stall=1 in CLEAR or on starve; any core_wr in that cycle is not written and sets drop_err
//   (core is required to repeat; drop_err flags a core that ignored the stall). drop_err clears
//   only on reset.
//  core_rd==0 with core_wr=1 is treated as no core write (buffer may drain that cycle).
//  Reset mid-CLEAR or with a full buffer: sequence restarts at idx 1, pending debug entry lost, no dbg_done.
// TESTING
//  Reset release -> 31 cycles ru_wr=1, ru_rd 1..31, data 0; busy falls cycle 32; dbg_ready rises.
//  RUN, core_wr=0, dbg write x5=0xDEADBEEF -> next cycle ru_wr=1 rd=5 data=DEADBEEF; dbg_done after.
//  core_wr every cycle to x3, dbg x7 buffered -> stall on wait_cnt=8, x7 written, drop_err stays 0.
//  Same as above but core keeps core_wr=1 during stall -> x3 not written that cycle, drop_err=1.
//  dbg write to x0 -> ru_wr stays 0, dbg_done pulses; core_wr to x0 -> ru_wr=0.
//  Assert RSTn low at CLEAR idx 12 with dbg pending -> restart at idx 1, no dbg_done, dbg_ready=0.

Source files
------------

// File: rtl/ru_write_arbiter.sv
// ru_write_arbiter
// Owns the single write port of the register unit. After reset it walks x1..x(NREG-1)
// writing zero, then shares the port between core writeback (priority) and a one-entry
// debug/loader buffer. A buffered debug write that waits too long stalls the core so
// the entry can drain.
module ru_write_arbiter #(
    parameter int NREG           = 32,
    parameter int DW             = 32,
    parameter int STARVE_LIMIT   = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     core_wr,
    input  logic [$clog2(NREG)-1:0]  core_rd,
    input  logic [DW-1:0]            core_data,
    input  logic                     dbg_valid,
    output logic                     dbg_ready,
    input  logic [$clog2(NREG)-1:0]  dbg_rd,
    input  logic [DW-1:0]            dbg_data,
    output logic                     dbg_done,
    output logic                     ru_wr,
    output logic [$clog2(NREG)-1:0]  ru_rd,
    output logic [DW-1:0]            ru_data,
    output logic                     core_stall,
    output logic                     busy,
    output logic                     drop_err
);

    localparam int IW  = $clog2(NREG);
    localparam int WCW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    clr_idx;
    logic             buf_full;
    logic [IW-1:0]    buf_rd;
    logic [DW-1:0]    buf_data;
    logic [WCW-1:0]   wait_cnt;

    logic             starve;   // buffered entry has waited long enough to preempt the core
    logic             core_go;  // core has a real (non-x0) write this cycle
    logic             drain;    // buffer retires at the coming edge
    logic             hold;     // buffer full but the core owns the port this cycle

    assign starve  = buf_full && (wait_cnt >= WCW'(STARVE_LIMIT));
    assign core_go = core_wr && (core_rd != '0);

    // State register: CLEAR after reset unless the clear sequence is disabled.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave CLEAR once the last register index has been written.
    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_idx == IW'(NREG - 1)) begin
            state_nxt = ST_RUN;
        end
    end

    // Outputs and port arbitration: clear walk, then starve > core > buffer drain.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        busy       = 1'b0;
        core_stall = 1'b0;
        dbg_ready  = 1'b0;
        ru_wr      = 1'b0;
        ru_rd      = '0;
        ru_data    = '0;
        drain      = 1'b0;
        hold       = 1'b0;
        if (state == ST_CLEAR) begin
            busy       = 1'b1;
            core_stall = 1'b1;
            ru_wr      = 1'b1;
            ru_rd      = clr_idx;
        end else begin
            dbg_ready = !buf_full;
            if (starve) begin
                core_stall = 1'b1;
                drain      = 1'b1;
            end else if (core_go) begin
                ru_wr   = 1'b1;
                ru_rd   = core_rd;
                ru_data = core_data;
                hold    = buf_full;
            end else if (buf_full) begin
                drain = 1'b1;
            end
            // A buffered write to x0 retires without touching the port.
            if (drain && buf_rd != '0) begin
                ru_wr   = 1'b1;
                ru_rd   = buf_rd;
                ru_data = buf_data;
            end
        end
    end

    // Control state: clear index, buffer occupancy, starvation count, done pulse, sticky error.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            clr_idx  <= IW'(1);
            buf_full <= 1'b0;
            wait_cnt <= '0;
            dbg_done <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            dbg_done <= drain;
            if (core_stall && core_wr) begin
                drop_err <= 1'b1;
            end
            if (state == ST_CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
            end
            if (drain) begin
                buf_full <= 1'b0;
                wait_cnt <= '0;
            end else if (dbg_valid && dbg_ready) begin
                buf_full <= 1'b1;
                wait_cnt <= '0;
            end else if (hold && wait_cnt < WCW'(STARVE_LIMIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Buffer payload: captured on acceptance.
    // NOTE: payload registers are not reset; buf_full qualifies every use of them.
    always_ff @(posedge CLK) begin
        if (dbg_valid && dbg_ready) begin
            buf_rd   <= dbg_rd;
            buf_data <= dbg_data;
        end
    end

endmodule

// File: tb/tb_ru_write_arbiter.sv
// tb_ru_write_arbiter
// Clear walk, table-driven arbitration vectors, starvation sequences and resets with
// pending debug traffic. Port writes in RUN are scoreboarded against an expected queue.
module tb_ru_write_arbiter;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        core_wr = 1'b0;
    logic [4:0]  core_rd = '0;
    logic [31:0] core_data = '0;
    logic        dbg_valid = 1'b0;
    logic        dbg_ready;
    logic [4:0]  dbg_rd = '0;
    logic [31:0] dbg_data = '0;
    logic        dbg_done;
    logic        ru_wr;
    logic [4:0]  ru_rd;
    logic [31:0] ru_data;
    logic        core_stall;
    logic        busy;
    logic        drop_err;

    ru_write_arbiter #(
        .NREG(32), .DW(32), .STARVE_LIMIT(8), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .CLK(CLK), .RSTn(RSTn),
        .core_wr(core_wr), .core_rd(core_rd), .core_data(core_data),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_rd(dbg_rd), .dbg_data(dbg_data),
        .dbg_done(dbg_done),
        .ru_wr(ru_wr), .ru_rd(ru_rd), .ru_data(ru_data),
        .core_stall(core_stall), .busy(busy), .drop_err(drop_err)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic        cw;
        logic [4:0]  crd;
        logic [31:0] cdat;
        logic        dv;
        logic [4:0]  drd;
        logic [31:0] ddat;
        logic        e_wr;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_rdy;
        logic        e_done;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cw, input logic [4:0] crd, input logic [31:0] cdat,
                         input logic dv, input logic [4:0] drd, input logic [31:0] ddat);
        core_wr   = cw;
        core_rd   = crd;
        core_data = cdat;
        dbg_valid = dv;
        dbg_rd    = drd;
        dbg_data  = ddat;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back('{rd, data});
    endtask

    function automatic vec_t mk(input logic cw, input logic [4:0] crd, input logic [31:0] cdat,
                                input logic dv, input logic [4:0] drd, input logic [31:0] ddat,
                                input logic e_wr, input logic [4:0] e_rd, input logic [31:0] e_data,
                                input logic e_rdy, input logic e_done);
        vec_t v;
        v.cw = cw; v.crd = crd; v.cdat = cdat;
        v.dv = dv; v.drd = drd; v.ddat = ddat;
        v.e_wr = e_wr; v.e_rd = e_rd; v.e_data = e_data;
        v.e_rdy = e_rdy; v.e_done = e_done;
        return v;
    endfunction

    // Scoreboard: every RUN-phase port write must match the oldest expected write.
    always @(negedge CLK) begin
        if (mon_en && ru_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got write rd=%0d data=0x%0h, expected none", ru_rd, ru_data);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("sb_rd", {27'b0, ru_rd}, {27'b0, w.rd});
                check("sb_data", ru_data, w.data);
            end
        end
    end

    // Walks n clear cycles from idx 1, checking the port and status each cycle.
    task automatic run_clear(input int n, input logic dv);
        for (int i = 1; i <= n; i++) begin
            drive(1'b0, 5'd0, 32'h0, dv, 5'd21, 32'hABCD_0021);
            @(negedge CLK);
            check("clr_wr", {31'b0, ru_wr}, 32'd1);
            check("clr_rd", {27'b0, ru_rd}, i);
            check("clr_data", ru_data, 32'h0);
            check("clr_busy", {31'b0, busy}, 32'd1);
            check("clr_ready", {31'b0, dbg_ready}, 32'd0);
            check("clr_done", {31'b0, dbg_done}, 32'd0);
            step();
        end
    endtask

    // Debug entry buffered behind a core writing x3 every cycle; stall lands on wait 8.
    task automatic starve_seq(input logic cw_in_stall, input logic exp_drop);
        drive(1'b1, 5'd3, 32'h3333_0000, 1'b1, 5'd7, 32'h7777_0007);
        expect_write(5'd3, 32'h3333_0000);
        @(negedge CLK);
        check("stv_ready0", {31'b0, dbg_ready}, 32'd1);
        check("stv_stall0", {31'b0, core_stall}, 32'd0);
        step();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 5'd3, 32'h3333_0000 + k, 1'b0, 5'd0, 32'h0);
            expect_write(5'd3, 32'h3333_0000 + k);
            @(negedge CLK);
            check("stv_nostall", {31'b0, core_stall}, 32'd0);
            check("stv_ready", {31'b0, dbg_ready}, 32'd0);
            step();
        end
        drive(cw_in_stall, 5'd3, 32'h0000_0BAD, 1'b0, 5'd0, 32'h0);
        expect_write(5'd7, 32'h7777_0007);
        @(negedge CLK);
        check("stv_stall", {31'b0, core_stall}, 32'd1);
        check("stv_wr", {31'b0, ru_wr}, 32'd1);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge CLK);
        check("stv_done", {31'b0, dbg_done}, 32'd1);
        check("stv_drop", {31'b0, drop_err}, {31'b0, exp_drop});
        check("stv_unstall", {31'b0, core_stall}, 32'd0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset state
        @(negedge CLK);
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_stall", {31'b0, core_stall}, 32'd1);
        check("rst_ready", {31'b0, dbg_ready}, 32'd0);
        check("rst_wr", {31'b0, ru_wr}, 32'd1);
        check("rst_rd", {27'b0, ru_rd}, 32'd1);
        check("rst_done", {31'b0, dbg_done}, 32'd0);
        check("rst_drop", {31'b0, drop_err}, 32'd0);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;

        // Clear walk x1..x31, then RUN
        run_clear(31, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge CLK);
        check("run_busy", {31'b0, busy}, 32'd0);
        check("run_ready", {31'b0, dbg_ready}, 32'd1);
        check("run_stall", {31'b0, core_stall}, 32'd0);
        check("run_wr", {31'b0, ru_wr}, 32'd0);
        mon_en = 1'b1;
        step();

        //                cw  crd    cdat          dv  drd    ddat          wr  rd     data          rdy done
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        1, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd5,  32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 1));
        vecs.push_back(mk(1, 5'd9,  32'h11111111, 1, 5'd10, 32'h22222222, 1, 5'd9,  32'h11111111, 1, 0));
        vecs.push_back(mk(1, 5'd11, 32'h33333333, 0, 5'd0,  32'h0,        1, 5'd11, 32'h33333333, 0, 0));
        vecs.push_back(mk(1, 5'd0,  32'h44444444, 0, 5'd0,  32'h0,        1, 5'd10, 32'h22222222, 0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd12, 32'h55555555, 0, 5'd0,  32'h0,        1, 1));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd13, 32'hDEAD0013, 1, 5'd12, 32'h55555555, 0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd13, 32'h66660013, 0, 5'd0,  32'h0,        1, 1));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd13, 32'h66660013, 0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd0,  32'h77777777, 0, 5'd0,  32'h0,        1, 1));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 1));
        vecs.push_back(mk(1, 5'd0,  32'h88888888, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].cw, vecs[i].crd, vecs[i].cdat, vecs[i].dv, vecs[i].drd, vecs[i].ddat);
            if (vecs[i].e_wr) expect_write(vecs[i].e_rd, vecs[i].e_data);
            @(negedge CLK);
            check($sformatf("vec%0d_wr", i), {31'b0, ru_wr}, {31'b0, vecs[i].e_wr});
            check($sformatf("vec%0d_ready", i), {31'b0, dbg_ready}, {31'b0, vecs[i].e_rdy});
            check($sformatf("vec%0d_done", i), {31'b0, dbg_done}, {31'b0, vecs[i].e_done});
            check($sformatf("vec%0d_stall", i), {31'b0, core_stall}, 32'd0);
            step();
        end

        // Starvation with an obedient core, then with a core that ignores the stall
        starve_seq(1'b0, 1'b0);
        starve_seq(1'b1, 1'b1);

        // Reset with a full buffer: the pending entry is lost
        drive(1'b1, 5'd4, 32'h4444_0001, 1'b1, 5'd20, 32'h2020_2020);
        expect_write(5'd4, 32'h4444_0001);
        @(negedge CLK);
        check("fb_accept_ready", {31'b0, dbg_ready}, 32'd1);
        step();
        drive(1'b1, 5'd4, 32'h4444_0002, 1'b0, 5'd0, 32'h0);
        expect_write(5'd4, 32'h4444_0002);
        @(negedge CLK);
        check("fb_full_ready", {31'b0, dbg_ready}, 32'd0);
        #1;
        mon_en = 1'b0;
        RSTn = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd21, 32'hABCD_0021);
        #1;
        check("fb_rst_busy", {31'b0, busy}, 32'd1);
        check("fb_rst_rd", {27'b0, ru_rd}, 32'd1);
        check("fb_rst_ready", {31'b0, dbg_ready}, 32'd0);
        check("fb_rst_drop", {31'b0, drop_err}, 32'd0);
        @(posedge CLK);
        #1;
        check("fb_rst_done", {31'b0, dbg_done}, 32'd0);
        RSTn = 1'b1;

        // Reset at clear idx 12 with a debug request held
        run_clear(11, 1'b1);
        @(negedge CLK);
        check("mc_idx12", {27'b0, ru_rd}, 32'd12);
        #1;
        RSTn = 1'b0;
        #1;
        check("mc_rst_rd", {27'b0, ru_rd}, 32'd1);
        check("mc_rst_ready", {31'b0, dbg_ready}, 32'd0);
        check("mc_rst_done", {31'b0, dbg_done}, 32'd0);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        run_clear(31, 1'b1);

        // First RUN cycle accepts the held request, which drains next cycle
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd21, 32'hABCD_0021);
        @(negedge CLK);
        check("post_busy", {31'b0, busy}, 32'd0);
        check("post_ready", {31'b0, dbg_ready}, 32'd1);
        check("post_drop", {31'b0, drop_err}, 32'd0);
        check("post_wr", {31'b0, ru_wr}, 32'd0);
        mon_en = 1'b1;
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_write(5'd21, 32'hABCD_0021);
        @(negedge CLK);
        check("post_drain_wr", {31'b0, ru_wr}, 32'd1);
        step();
        @(negedge CLK);
        check("post_done", {31'b0, dbg_done}, 32'd1);
        step();

        check("sb_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
